// File: rtl/vta_host_arb_pkg.sv
// Shared types and constants for the VTA host-register arbiter.
package vta_host_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Data returned to the requester when a read is abandoned on timeout.
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    localparam int ERR_TMO   = 0;
    localparam int ERR_STRAY = 1;

endpackage

// File: rtl/vta_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, with wrap-around.
module vta_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               found
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[IDX_W'((int'(ptr) + off) % NUM_REQ)]) begin
                grant = IDX_W'((int'(ptr) + off) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vta_host_arb.sv
// Arbitrates several host-side requesters onto one register request port,
// keeping a single transaction outstanding and routing read data back.
//
// Handshakes: a requester's request is taken in the cycle where
// in_valid[i] && in_ready[i]; in_ready is only raised in IDLE, for at most
// one requester. Downstream, host_req_valid stays high with stable fields
// until the cycle host_req_deq is high, which completes the transfer.
module vta_host_arb #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             in_valid,
    output logic [NUM_REQ-1:0]             in_ready,
    input  logic [NUM_REQ-1:0]             in_opcode,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   in_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   in_value,
    output logic [NUM_REQ-1:0]             out_resp_valid,
    output logic [DATA_BITS-1:0]           out_resp_bits,
    output logic                           host_req_valid,
    output logic                           host_req_opcode,
    output logic [ADDR_BITS-1:0]           host_req_addr,
    output logic [DATA_BITS-1:0]           host_req_value,
    input  logic                           host_req_deq,
    input  logic                           host_resp_valid,
    input  logic [DATA_BITS-1:0]           host_resp_bits,
    output logic [1:0]                     err,
    output logic [1:0]                     dbg_state,
    output logic [$clog2(NUM_REQ)-1:0]     dbg_rr_ptr
);
    import vta_host_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state, state_nxt;
    logic [1:0]           rst_sync;
    logic                 run;
    logic [IDX_W-1:0]     pick_grant, grant_q, rr_ptr;
    logic                 pick_found, take;
    logic                 sel_op, op_q;
    logic [ADDR_BITS-1:0] sel_addr, addr_q;
    logic [DATA_BITS-1:0] sel_value, value_q, resp_bits_q;
    logic [NUM_REQ-1:0]   grant_oh, resp_valid_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 tmo_hit, finish_rd;
    logic [1:0]           err_q;

    // Reset is applied immediately but released through two flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    vta_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .found (pick_found)
    );

    // Select the picked requester's fields and the latched grant's one-hot.
    always_comb begin
        sel_op    = 1'b0;
        sel_addr  = '0;
        sel_value = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant == IDX_W'(i)) begin
                sel_op    = in_opcode[i];
                sel_addr  = in_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_value = in_value[i*DATA_BITS +: DATA_BITS];
            end
            if (grant_q == IDX_W'(i)) grant_oh[i] = 1'b1;
        end
    end

    assign tmo_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign finish_rd = (state == WAIT) && (host_resp_valid || tmo_hit);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, grant strobe and handshake outputs.
    always_comb begin
        state_nxt      = state;
        take           = 1'b0;
        in_ready       = '0;
        host_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (run && pick_found) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++)
                        in_ready[i] = (pick_grant == IDX_W'(i));
                end
            end
            ISSUE: begin
                host_req_valid = 1'b1;
                if (host_req_deq) state_nxt = (op_q == OP_WR) ? IDLE : WAIT;
            end
            WAIT: begin
                if (host_resp_valid || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request, advance the pointer, run the wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            grant_q <= '0;
            rr_ptr  <= '0;
            cnt_q   <= '0;
        end else begin
            if (take) begin
                op_q    <= sel_op;
                addr_q  <= sel_addr;
                value_q <= sel_value;
                grant_q <= pick_grant;
                rr_ptr  <= (pick_grant == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : pick_grant + IDX_W'(1);
            end
            if (state == ISSUE && host_req_deq) cnt_q <= '0;
            else if (state == WAIT)             cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Response return (real data wins over timeout) and sticky error flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= '0;
            resp_bits_q  <= '0;
            err_q        <= 2'b00;
        end else begin
            resp_valid_q <= '0;
            if (finish_rd) begin
                resp_valid_q <= grant_oh;
                if (host_resp_valid) begin
                    resp_bits_q <= host_resp_bits;
                end else begin
                    resp_bits_q     <= DATA_BITS'(TMO_DATA);
                    err_q[ERR_TMO]  <= 1'b1;
                end
            end
            if (host_resp_valid && state != WAIT) err_q[ERR_STRAY] <= 1'b1;
        end
    end

    assign out_resp_valid  = resp_valid_q;
    assign out_resp_bits   = resp_bits_q;
    assign host_req_opcode = op_q;
    assign host_req_addr   = addr_q;
    assign host_req_value  = value_q;
    assign err             = err_q;
    assign dbg_state       = state;
    assign dbg_rr_ptr      = rr_ptr;

endmodule

// File: tb/tb_vta_host_arb.sv
// Bench for vta_host_arb: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the arbiter.
module tb_vta_host_arb;
    localparam int NREQ = 2;
    localparam int TMO  = 16;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clock, reset;
    logic [1:0]  in_valid, in_ready, in_opcode, out_resp_valid, err, dbg_state;
    logic [15:0] in_addr;
    logic [63:0] in_value;
    logic [31:0] out_resp_bits, host_req_value, host_resp_bits;
    logic        host_req_valid, host_req_opcode, host_req_deq, host_resp_valid;
    logic [7:0]  host_req_addr;
    logic [0:0]  dbg_rr_ptr;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    logic [1:0]  m_err = 2'b00;
    logic [33:0] exp_q[$];

    logic        r_op[NREQ];
    logic [7:0]  r_addr[NREQ];
    logic [31:0] r_val[NREQ];

    vta_host_arb #(.NUM_REQ(2), .ADDR_BITS(8), .DATA_BITS(32), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_addr(in_addr), .in_value(in_value),
        .out_resp_valid(out_resp_valid), .out_resp_bits(out_resp_bits),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .err(err),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference grant rule: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [1:0] req, input int ptr);
        for (int off = 0; off < NREQ; off++)
            if (req[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        return -1;
    endfunction

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (out_resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {30'd0, out_resp_valid}, 32'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("sb_resp_vec", {30'd0, out_resp_valid}, {30'd0, e[33:32]});
                check("sb_resp_bits", out_resp_bits, e[31:0]);
            end
        end
    end

    task automatic randomize_noise();
        in_valid  = 2'($urandom_range(0, 3));
        in_opcode = 2'($urandom_range(0, 3));
        in_addr   = 16'($urandom);
        in_value  = {$urandom, $urandom};
    endtask

    // Driver: one full transaction. Called at 2 time units after a rising edge;
    // returns at the same phase. resp_wait >= TMO means the host never answers.
    task automatic do_txn(input logic [1:0] vmask, input int deq_wait, input int resp_wait,
                          input bit stray_en, input logic [31:0] rdata);
        int g;
        logic [1:0] oh;
        bit respond;
        for (int i = 0; i < NREQ; i++) begin
            in_opcode[i]          = r_op[i];
            in_addr[i*8 +: 8]     = r_addr[i];
            in_value[i*32 +: 32]  = r_val[i];
        end
        in_valid = vmask;
        #2;
        g = model_pick(vmask, m_ptr);
        oh = 2'b00;
        oh[g] = 1'b1;
        check("rr_ptr_before", {31'd0, dbg_rr_ptr}, m_ptr);
        check("in_ready_grant", {30'd0, in_ready}, {30'd0, oh});
        @(posedge clock); #2;
        m_ptr = (g + 1) % NREQ;
        for (int k = 0; k <= deq_wait; k++) begin
            randomize_noise();
            host_req_deq    = (k == deq_wait);
            host_resp_valid = stray_en && ($urandom_range(0, 3) == 0);
            host_resp_bits  = $urandom;
            if (host_resp_valid) m_err[1] = 1'b1;
            #2;
            check("issue_valid", {31'd0, host_req_valid}, 32'd1);
            check("issue_opcode", {31'd0, host_req_opcode}, {31'd0, r_op[g]});
            check("issue_addr", {24'd0, host_req_addr}, {24'd0, r_addr[g]});
            check("issue_value", host_req_value, r_val[g]);
            check("issue_no_ready", {30'd0, in_ready}, 32'd0);
            @(posedge clock); #2;
        end
        host_req_deq    = 1'b0;
        host_resp_valid = 1'b0;
        if (r_op[g] == 1'b1) begin
            #2;
            check("wr_done_valid", {31'd0, host_req_valid}, 32'd0);
            check("wr_done_state", {30'd0, dbg_state}, 32'd0);
        end else begin
            respond = (resp_wait < TMO);
            for (int w = 0; w < (respond ? resp_wait + 1 : TMO); w++) begin
                randomize_noise();
                host_resp_valid = respond && (w == resp_wait);
                host_resp_bits  = rdata;
                if (host_resp_valid) exp_q.push_back({oh, rdata});
                #2;
                check("wait_valid", {31'd0, host_req_valid}, 32'd0);
                check("wait_no_ready", {30'd0, in_ready}, 32'd0);
                check("wait_no_pulse", {30'd0, out_resp_valid}, 32'd0);
                @(posedge clock); #2;
            end
            host_resp_valid = 1'b0;
            if (!respond) begin
                exp_q.push_back({oh, DEAD});
                m_err[0] = 1'b1;
            end
            #2;
            check("rd_pulse_vec", {30'd0, out_resp_valid}, {30'd0, oh});
            check("rd_pulse_bits", out_resp_bits, respond ? rdata : DEAD);
        end
        check("err_flags", {30'd0, err}, {30'd0, m_err});
        in_valid = 2'b00;
        @(posedge clock); #2;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = '0; in_opcode = '0; in_addr = '0; in_value = '0;
        host_req_deq = 1'b0; host_resp_valid = 1'b0; host_resp_bits = '0;
        #3;
        check("rst_in_ready", {30'd0, in_ready}, 32'd0);
        check("rst_host_valid", {31'd0, host_req_valid}, 32'd0);
        check("rst_resp_valid", {30'd0, out_resp_valid}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_ptr", {31'd0, dbg_rr_ptr}, 32'd0);
        @(posedge clock); #2;
        // Release reset with a request already pending; grant must wait for the synchroniser.
        reset = 1'b1;
        in_valid = 2'b01;
        #2;
        check("sync_ready0", {30'd0, in_ready}, 32'd0);
        @(posedge clock); #2;
        check("sync_ready1", {30'd0, in_ready}, 32'd0);
        in_valid = 2'b00;
        @(posedge clock); #2;
        @(posedge clock); #2;

        // Single write from requester 0, deq on third ISSUE cycle.
        r_op[0] = 1'b1; r_addr[0] = 8'h10; r_val[0] = 32'h1234_5678;
        r_op[1] = 1'b0; r_addr[1] = 8'h20; r_val[1] = 32'h0;
        do_txn(2'b01, 2, 0, 1'b0, 32'h0);

        // Read from requester 1, response two cycles after deq.
        do_txn(2'b10, 0, 1, 1'b0, 32'hCAFE_0001);

        // Both requesters reading back to back; grants must alternate.
        r_op[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            r_addr[0] = 8'($urandom); r_addr[1] = 8'($urandom);
            do_txn(2'b11, 0, 0, 1'b0, $urandom);
        end

        // Read that times out.
        do_txn(2'b01, 1, TMO, 1'b0, 32'h0);

        // Response on the very cycle the timeout would fire.
        do_txn(2'b10, 0, TMO - 1, 1'b0, 32'h5A5A_0F0F);

        // Stray response while idle.
        host_resp_valid = 1'b1;
        host_resp_bits  = 32'h1111_2222;
        @(posedge clock); #2;
        host_resp_valid = 1'b0;
        m_err[1] = 1'b1;
        #2;
        check("stray_idle_err", {30'd0, err}, {30'd0, m_err});
        @(posedge clock); #2;

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                r_op[i]   = 1'($urandom_range(0, 1));
                r_addr[i] = 8'($urandom);
                r_val[i]  = $urandom;
            end
            do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 19),
                   1'($urandom_range(0, 1)), $urandom);
        end

        // Reset in WAIT, then a late response after release.
        r_op[0] = 1'b0; r_addr[0] = 8'h44;
        in_opcode = 2'b00; in_addr = {8'h00, 8'h44};
        in_valid = 2'b01;
        #2;
        check("abort_grant", {30'd0, in_ready}, {30'd0, (m_ptr == 0) ? 2'b01 : 2'b01});
        @(posedge clock); #2;
        in_valid = 2'b00;
        host_req_deq = 1'b1;
        #2;
        check("abort_issue", {31'd0, host_req_valid}, 32'd1);
        @(posedge clock); #2;
        host_req_deq = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        m_ptr = 0;
        m_err = 2'b00;
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        check("abort_ptr", {31'd0, dbg_rr_ptr}, 32'd0);
        check("abort_err", {30'd0, err}, 32'd0);
        check("abort_host_valid", {31'd0, host_req_valid}, 32'd0);
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
        end
        host_resp_valid = 1'b1;
        host_resp_bits  = 32'h7777_8888;
        @(posedge clock); #2;
        host_resp_valid = 1'b0;
        m_err[1] = 1'b1;
        #2;
        check("late_resp_err", {30'd0, err}, {30'd0, m_err});
        check("late_resp_ptr", {31'd0, dbg_rr_ptr}, m_ptr);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
